// File: rtl/store_buffer_pkg.sv
// Shared store op codes and the store-buffer entry payload.
package store_buffer_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned WADR_W = ADDR_W - 2;

    // Memory op codes, matching the load/store set decoded in EXE
    localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    // One buffered store: word address, byte enables, lane-replicated data
    typedef struct packed {
        logic [WADR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_lane_encoder.sv
// Decodes a store op into alignment error, byte strobe and replicated data.
module store_lane_encoder
    import store_buffer_pkg::*;
(
    input  logic [OP_W-1:0]   alucontrol_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              is_store_o,
    output logic              ades_o,
    output logic [STRB_W-1:0] strb_o,
    output logic [DATA_W-1:0] data_o
);

    // Per-op lane steering; non-store ops produce all zeros
    always_comb begin
        is_store_o = 1'b0;
        ades_o     = 1'b0;
        strb_o     = '0;
        data_o     = '0;
        case (alucontrol_i)
            EXE_SW_OP: begin
                is_store_o = 1'b1;
                ades_o     = (addr_lo_i != 2'b00);
                strb_o     = 4'b1111;
                data_o     = wdata_i;
            end
            EXE_SH_OP: begin
                is_store_o = 1'b1;
                ades_o     = addr_lo_i[0];
                strb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                data_o     = {wdata_i[15:0], wdata_i[15:0]};
            end
            EXE_SB_OP: begin
                is_store_o = 1'b1;
                strb_o     = STRB_W'(4'b0001 << addr_lo_i);
                data_o     = {4{wdata_i[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store queue issuing writes over an addr_ok/data_ok handshake.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              st_validM,
    input  logic [OP_W-1:0]   alucontrolM,
    input  logic [ADDR_W-1:0] dataadrM,
    input  logic [DATA_W-1:0] writedataM,
    input  logic [ADDR_W-1:0] ld_adrM,
    output logic              adesM,
    output logic              st_stallM,
    output logic              ld_conflict,
    output logic              drained,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    sb_entry_t         fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  out_q, out_d;

    logic              is_store;
    logic              ades_raw;
    logic [STRB_W-1:0] enc_strb;
    logic [DATA_W-1:0] enc_data;
    logic              st_req, full, enq, deq, inc, dec;
    sb_entry_t         head;
    logic              unused_ld_lo;

    store_lane_encoder u_enc (
        .alucontrol_i (alucontrolM),
        .addr_lo_i    (dataadrM[1:0]),
        .wdata_i      (writedataM),
        .is_store_o   (is_store),
        .ades_o       (ades_raw),
        .strb_o       (enc_strb),
        .data_o       (enc_data)
    );

    assign unused_ld_lo = ^ld_adrM[1:0];

    assign st_req    = st_validM && is_store;
    assign full      = (count_q == DEPTH_C);
    assign adesM     = st_req && ades_raw;
    assign st_stallM = st_req && full;
    assign enq       = st_req && !ades_raw && !full;
    assign deq       = (state_q == S_REQ) && mem_addr_ok;
    assign inc       = deq;
    assign dec       = mem_data_ok && (out_q != '0);

    assign head      = fifo_q[rd_ptr_q];
    assign mem_req   = (state_q == S_REQ);
    assign mem_wr    = 1'b1;
    assign mem_addr  = {head.addr, 2'b00};
    assign mem_wstrb = head.strb;
    assign mem_wdata = head.data;
    assign drained   = (count_q == '0) && (out_q == '0) && (state_q == S_IDLE);

    // Pointer, occupancy and outstanding-write bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        count_d  = count_q;
        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
        end
        out_d = out_q;
        if (inc && !dec) begin
            out_d = out_q + CNT_W'(1);
        end else if (dec && !inc) begin
            out_d = out_q - CNT_W'(1);
        end
    end

    // Issue FSM next state; looks at next occupancy so a fresh store issues one cycle later
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((count_d != '0) && (out_d < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_addr_ok && ((count_d == '0) || (out_d >= DEPTH_C))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load ordering: same word still queued, or any write not yet completed
    always_comb begin
        ld_conflict = (out_q != '0);
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (fifo_q[rd_ptr_q + PTR_W'(i)].addr == ld_adrM[ADDR_W-1:2])) begin
                ld_conflict = 1'b1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    // Entry storage; cleared on reset so the memory-side fields read zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (enq) begin
            fifo_q[wr_ptr_q] <= '{addr: dataadrM[ADDR_W-1:2], strb: enc_strb, data: enc_data};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=2).
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_validM;
    logic [7:0]  alucontrolM;
    logic [31:0] dataadrM;
    logic [31:0] writedataM;
    logic [31:0] ld_adrM;
    logic        adesM, st_stallM, ld_conflict, drained;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok, mem_data_ok;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .st_validM   (st_validM),
        .alucontrolM (alucontrolM),
        .dataadrM    (dataadrM),
        .writedataM  (writedataM),
        .ld_adrM     (ld_adrM),
        .adesM       (adesM),
        .st_stallM   (st_stallM),
        .ld_conflict (ld_conflict),
        .drained     (drained),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        st_validM   = 1'b1;
        alucontrolM = op;
        dataadrM    = a;
        writedataM  = d;
        #1;
    endtask

    task automatic idle_st();
        st_validM   = 1'b0;
        alucontrolM = 8'h00;
        #1;
    endtask

    initial begin
        resetn = 1'b0; st_validM = 1'b0; alucontrolM = '0; dataadrM = '0;
        writedataM = '0; ld_adrM = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_drained", 32'(drained), 32'd1);
        chk("rst_stall", 32'(st_stallM), 32'd0);
        chk("rst_ldc", 32'(ld_conflict), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("mem_wr", 32'(mem_wr), 32'd1);
        resetn = 1'b1;
        tick();

        // SB at 0x1000_0003
        drive_st(EXE_SB_OP, 32'h1000_0003, 32'h1234_5678);
        chk("sb_ades", 32'(adesM), 32'd0);
        chk("sb_stall", 32'(st_stallM), 32'd0);
        tick();
        idle_st();
        chk("sb_req", 32'(mem_req), 32'd1);
        chk("sb_addr", mem_addr, 32'h1000_0000);
        chk("sb_strb", 32'(mem_wstrb), 32'h8);
        chk("sb_data", mem_wdata, 32'h7878_7878);
        chk("sb_ldc_other", 32'(ld_conflict), 32'd0);
        ld_adrM = 32'h1000_0001; #1;
        chk("sb_ldc_same", 32'(ld_conflict), 32'd1);
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0; #1;
        chk("sb_req_done", 32'(mem_req), 32'd0);
        chk("sb_ldc_outst", 32'(ld_conflict), 32'd1);
        chk("sb_not_drained", 32'(drained), 32'd0);
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0; #1;
        chk("sb_drained", 32'(drained), 32'd1);
        chk("sb_ldc_clear", 32'(ld_conflict), 32'd0);

        // SH at 0x2002 then misaligned SH at 0x2001
        drive_st(EXE_SH_OP, 32'h0000_2002, 32'h1234_5678);
        tick();
        drive_st(EXE_SH_OP, 32'h0000_2001, 32'h1234_5678);
        chk("sh_ades", 32'(adesM), 32'd1);
        chk("sh_addr", mem_addr, 32'h0000_2000);
        chk("sh_strb", 32'(mem_wstrb), 32'hC);
        chk("sh_data", mem_wdata, 32'h5678_5678);
        tick();
        idle_st();
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0; #1;
        chk("sh_only_one", 32'(mem_req), 32'd0);
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0; #1;
        chk("sh_drained", 32'(drained), 32'd1);

        // Misaligned SW flags ades; non-store op never does
        drive_st(EXE_SW_OP, 32'h0000_6002, 32'h0);
        chk("sw_ades", 32'(adesM), 32'd1);
        drive_st(EXE_LW_OP, 32'h0000_6002, 32'h0);
        chk("ld_no_ades", 32'(adesM), 32'd0);
        tick();
        idle_st();
        chk("ades_not_queued", 32'(drained), 32'd1);

        // Three back-to-back SWs, addr_ok low
        drive_st(EXE_SW_OP, 32'h0000_3000, 32'hAAAA_0001);
        tick();
        drive_st(EXE_SW_OP, 32'h0000_3004, 32'hBBBB_0002);
        tick();
        drive_st(EXE_SW_OP, 32'h0000_3008, 32'hCCCC_0003);
        chk("sw3_stall", 32'(st_stallM), 32'd1);
        tick();
        chk("sw3_stall_hold", 32'(st_stallM), 32'd1);
        chk("sw3_head_addr", mem_addr, 32'h0000_3000);
        chk("sw3_head_data", mem_wdata, 32'hAAAA_0001);
        ld_adrM = 32'h0000_3004; #1;
        chk("sw3_ldc_queued", 32'(ld_conflict), 32'd1);
        mem_addr_ok = 1'b1; #1;
        chk("sw3_stall_same_cycle", 32'(st_stallM), 32'd1);
        tick();
        chk("sw3_stall_off", 32'(st_stallM), 32'd0);
        chk("sw3_b_addr", mem_addr, 32'h0000_3004);
        chk("sw3_b_data", mem_wdata, 32'hBBBB_0002);
        chk("sw3_b_req", 32'(mem_req), 32'd1);
        tick();
        idle_st();
        mem_addr_ok = 1'b0; #1;
        chk("sw3_outst_full", 32'(mem_req), 32'd0);
        chk("sw3_c_addr", mem_addr, 32'h0000_3008);
        chk("sw3_c_data", mem_wdata, 32'hCCCC_0003);
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0; #1;
        chk("sw3_c_req", 32'(mem_req), 32'd1);
        chk("sw3_ldc_outst", 32'(ld_conflict), 32'd1);

        // addr_ok and data_ok together with one outstanding
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; #1;
        chk("both_req", 32'(mem_req), 32'd0);
        chk("both_ldc", 32'(ld_conflict), 32'd1);
        chk("both_not_drained", 32'(drained), 32'd0);
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0; #1;
        chk("last_done_drained", 32'(drained), 32'd1);
        chk("last_done_ldc", 32'(ld_conflict), 32'd0);
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0; #1;
        chk("stray_drained", 32'(drained), 32'd1);
        chk("stray_ldc", 32'(ld_conflict), 32'd0);

        // Reset while in REQ with two entries queued
        drive_st(EXE_SW_OP, 32'h0000_4000, 32'h1111_1111);
        tick();
        drive_st(EXE_SW_OP, 32'h0000_4004, 32'h2222_2222);
        tick();
        idle_st();
        ld_adrM = 32'h0000_4000; #1;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        resetn = 1'b0; #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_drained", 32'(drained), 32'd1);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_ldc", 32'(ld_conflict), 32'd0);
        tick();
        resetn = 1'b1;
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0;
        tick();
        chk("post_rst_req", 32'(mem_req), 32'd0);
        chk("post_rst_drained", 32'(drained), 32'd1);

        // New store after reset issues normally
        drive_st(EXE_SB_OP, 32'h0000_5001, 32'h0000_00AB);
        tick();
        idle_st();
        chk("new_req", 32'(mem_req), 32'd1);
        chk("new_addr", mem_addr, 32'h0000_5000);
        chk("new_strb", 32'(mem_wstrb), 32'h2);
        chk("new_data", mem_wdata, 32'hABAB_ABAB);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side counterpart of the W-stage load data handler. It takes SB/SH/SW requests from the MEM stage, checks alignment, builds the byte strobe and lane-replicated write data, and queues them in a small FIFO. It then issues them to the data SRAM over an addr_ok/data_ok handshake. It gives the pipeline a stall, a load-ordering conflict flag and a drained indicator, so loads never bypass older buffered stores.

## Interface
- DEPTH, 2: FIFO entries; also the maximum number of outstanding (accepted, not yet data_ok) writes; power of two, ≥2
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- st_validM  in  1  MEM-stage memory-write request (already qualified by flush/exception)
- alucontrolM  in  8  op code; only EXE_SW_OP, EXE_SH_OP, EXE_SB_OP count as stores
- dataadrM  in  32  effective byte address
- writedataM  in  32  rt value, unshifted
- ld_adrM  in  32  address of a MEM-stage load, for the conflict check
- adesM  out  1  store address error, combinational
- st_stallM  out  1  stall the MEM stage; the store is not accepted this cycle
- ld_conflict  out  1  the load must wait for older stores
- drained  out  1  FIFO empty and no outstanding writes
- mem_req  out  1  write request valid
- mem_wr  out  1  constant 1
- mem_addr  out  32  word-aligned address, with [1:0] forced to 00
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  one outstanding write completed

## Operation
- A cycle is a store request when st_validM is high and alucontrolM is SW, SH or SB.
- Encoding (a = dataadrM[1:0], d = writedataM):
  - SW: ades if a≠00; otherwise strb 1111 and data d.
  - SH: ades if a[0]=1; otherwise strb 0011 (a[1]=0) or 1100 (a[1]=1), and data {d[15:0],d[15:0]}.
  - SB: strb = 0001<<a, data {4{d[7:0]}}.
- adesM is asserted only for store requests.
- Enqueue on a store request with !adesM && !full. An ades store is never enqueued.
- st_stallM = store request && full. Full is the registered count == DEPTH, so a dequeue in the same cycle does not relieve the stall.
- FIFO entries hold {addr[31:2], strb, data}. Head fields drive mem_addr, mem_wstrb and mem_wdata directly.
- Issue FSM:
  - IDLE→REQ when the FIFO is non-empty and outstanding < DEPTH.
  - In REQ, mem_req=1. On mem_addr_ok: pop the head and increment outstanding. Then return to IDLE if the FIFO would become empty or outstanding would reach DEPTH; otherwise stay in REQ for the next entry back-to-back.
- Outstanding counter: +1 on addr_ok, −1 on data_ok, net 0 when both occur. It never goes below 0; a stray data_ok at 0 is ignored.
- ld_conflict = (any valid entry with addr[31:2]==ld_adrM[31:2]) || outstanding≠0. It is combinational and independent of alucontrol.
- drained = FIFO empty && outstanding==0 && state==IDLE.

## Timing
- Reset values:
  - count, pointers, outstanding: 0
  - state: IDLE
  - mem_req, st_stallM, ld_conflict: 0
  - drained: 1
  - mem_addr, mem_wstrb, mem_wdata: 0
- Latency: a store enqueued at edge N drives mem_req high from cycle N+1. mem_req is registered through the FSM.
- While mem_req=1 && !mem_addr_ok, mem_addr, mem_wstrb and mem_wdata hold stable.
- mem_req never drops without an addr_ok.
- Simultaneous enqueue and dequeue: count is unchanged, and the new entry goes to the tail.
- Pointers wrap modulo DEPTH.
- mem_data_ok may arrive in the same cycle as addr_ok, but only for an earlier transaction.
- Reset mid-operation flushes all entries and in-flight state immediately. Late data_ok pulses after reset are absorbed by the underflow guard.

## Structure
- EXE_SW_OP, EXE_SH_OP and EXE_SB_OP come from the shared defines header, alongside the load op codes. No new constants are needed apart from the FSM state encoding, which stays local.
- Sub-module store_lane_encoder: purely combinational, takes (alucontrol, addr[1:0], wdata) and returns (is_store, ades, strb, data).
- The FIFO, FSM and counter live inline in store_buffer.

## Test plan
- SB at 0x1000_0003, d=0x1234_5678 → entry with strb 1000, data 0x7878_7878; mem_addr 0x1000_0000 and mem_req=1 one cycle later.
- SH at 0x2002, then SH at 0x2001 → first gives strb 1100, data 0x5678_5678; second gives adesM=1 and is not enqueued, and the FIFO count stays 1.
- Three back-to-back SWs with mem_addr_ok held low (DEPTH=2) → the third sees st_stallM=1 until the first addr_ok; the order is preserved at the memory side.
- Load at 0x3004 while an SW to 0x3004 is queued → ld_conflict=1; it clears only after that write's data_ok and once no other entries are outstanding.
- addr_ok and data_ok in the same cycle with outstanding=1 → outstanding stays 1; a stray data_ok with outstanding=0 leaves it at 0.
- resetn pulled low while in REQ with 2 entries queued → mem_req=0 and drained=1 immediately; no issue occurs after release until a new store arrives.
